cpu_decode_stage: RTL and testbench
===================================

// Module: cpu_decode_stage
// PURPOSE
//  Registered RV32I decode stage between fetch and execute, built on a combinational decoder.
//  - Adds a valid/ready handshake on both sides, a 2-entry skid buffer, flush and fetch-fault passthrough.
//  - Optional M-extension and Zicsr decode.
//  - Output is a decoded-instruction bundle, tagged with its PC, for the execute stage.
// PARAMETERS
//  ENABLE_M      0   1: opcode_op with funct7=7'h01 decodes as `decode_action_muldiv; 0: illegal
//  ENABLE_ZICSR  1   0: all csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci decode as illegal
//  PC_WIDTH      32  width of the pc fields
// PORTS
//  clk                 in   1         rising-edge clock
//  reset_n             in   1         asynchronous reset, active low
//  flush               in   1         discard all held and in-flight instructions
//  fetch_valid         in   1         fetch offers an instruction
//  fetch_ready         out  1         decode stage accepts this cycle
//  fetch_instruction   in   32        raw instruction word
//  fetch_pc            in   PC_WIDTH  address of fetch_instruction
//  fetch_fault         in   1         fetch raised an instruction access fault; the word is garbage
//  decode_valid        out  1         decoded bundle is valid
//  decode_ready        in   1         execute consumes the bundle
//  decode_pc           out  PC_WIDTH  PC of the bundle
//  decode_instruction  out  32        raw word, used as mtval for illegal-instruction traps
//  decode_funct7       out  7         instruction[31:25]
//  decode_funct3       out  3         instruction[14:12]
//  decode_rd           out  5         instruction[11:7]
//  decode_rs1          out  5         instruction[19:15]
//  decode_rs2          out  5         instruction[24:20]
//  decode_opcode       out  7         instruction[6:0]
//  decode_immediate    out  32        sign/format-expanded immediate; 0 for R/R4/unknown formats
//  decode_action       out  `decode_action   action code
// BEHAVIOUR
//  Reset (asynchronous, reset_n=0):
//  - decode_valid=0, skid empty, all data outputs 0.
//  - fetch_ready=1 once reset_n is high.
//  Latency and ordering:
//  - An instruction accepted at edge N drives the outputs from edge N onward, valid after N.
//  - Strict FIFO order, no duplication or loss except on flush.
//  Handshake:
//  - Transfer in when fetch_valid & fetch_ready; transfer out when decode_valid & decode_ready.
//  - fetch_ready = !skid_valid (a registered term; no combinational path from decode_ready).
//  - Output register empty, or draining this cycle: the incoming bundle loads the output register.
//  - Output register full and stalled: the incoming bundle loads the skid.
//  - Skid full and output drains: skid -> output register; fetch_ready rises the next cycle.
//  - Held outputs stay stable while decode_valid & !decode_ready.
//  flush:
//  - Next edge clears decode_valid and skid_valid.
//  - A fetch handshake in the same cycle is dropped.
//  - flush has priority over every other event.
//  Decode rules, from instruction bits only, evaluated before registering:
//  - instruction[1:0] != 2'b11 -> `decode_action_trap_illegal_instruction (no RVC).
//  - fetch_fault=1 -> `decode_action_trap_instruction_access_fault; wins over all other decode.
//  - load: lb/lh/lw/lbu/lhu, else illegal. store: sb/sh/sw, else illegal.
//  - branch: beq/bne/blt/bge/bltu/bgeu, else illegal.
//  - jalr requires funct3=0. jal, lui and auipc are always legal.
//  - op_imm: slli needs funct7=0; srli/srai need funct7 in {0, 7'h20}; all else legal.
//  - op:
//    - funct7=0: legal.
//    - funct7=7'h20: legal only with funct3 add/sub or srl/sra.
//    - funct7=7'h01: legal iff ENABLE_M.
//    - anything else: illegal.
//  - misc_mem:
//    - fence requires imm[11:8]=0, rs1=0, rd=0.
//    - fence.i requires imm=0, rs1=0, rd=0.
//  - system:
//    - funct3=0 with rs1=0, rd=0, imm in {0,1} -> `decode_action_trap_ecall_ebreak; else illegal.
//    - CSR funct3 values -> `decode_action_csr if ENABLE_ZICSR.
//  - All other opcodes (fp, amo, custom, reserved, rv128, escapes) -> illegal.
//  Widths:
//  - Immediate formats: I/S/B/U/J per RV32I, sign bit instruction[31].
//  - decode_pc is fetch_pc unmodified.
// STRUCTURE
//  - cpu.vh gains `decode_action_muldiv and `decode_action_trap_instruction_access_fault; the width of `decode_action grows if needed.
//  - riscv.vh gains funct7 constants for the M extension.
//  - Sub-module cpu_decode_comb is purely combinational: instruction, fault -> fields, immediate, action.
//    It is instantiated once, on the fetch side.
//  - This module holds only the two bundle registers, the valid flags and the handshake/flush logic.
// TESTING
//  1. 0x00000013 (addi x0,x0,0), pc=0x100, decode_ready=1 -> next cycle valid, op_op_imm, imm=0, pc=0x100.
//  2. 0x02B50533 (mul a0,a0,a1) -> ENABLE_M=1: muldiv, rd=10, rs1=10, rs2=11; ENABLE_M=0: illegal, instruction=0x02B50533.
//  3. 0x00000073 -> ecall_ebreak; 0x00100073 -> ecall_ebreak; 0x00200073 -> illegal; 0x00001073 with ENABLE_ZICSR=0 -> illegal.
//  4. decode_ready=0 for 3 cycles while fetching pc 0x0,0x4,0x8 -> fetch_ready low after 2nd accept; on release outputs 0x0,0x4,0x8 in order, no gaps.
//  5. Full skid with flush=1 plus a simultaneous fetch handshake -> next cycle decode_valid=0, fetch_ready=1; nothing from before the flush appears.
//  6. fetch_fault=1 with word 0xFFFFFFFF -> access_fault action; reset_n pulsed low mid-stall -> decode_valid drops asynchronously, outputs read 0.

Source files
------------

// File: rtl/cpu_decode_stage_pkg.sv
// Shared types and encodings for the RV32I decode stage.
package cpu_decode_stage_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ACTION_WIDTH = 4;

  localparam logic [6:0] OPCODE_LOAD     = 7'h03;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC    = 7'h17;
  localparam logic [6:0] OPCODE_STORE    = 7'h23;
  localparam logic [6:0] OPCODE_OP       = 7'h33;
  localparam logic [6:0] OPCODE_LUI      = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
  localparam logic [6:0] OPCODE_JALR     = 7'h67;
  localparam logic [6:0] OPCODE_JAL      = 7'h6F;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;

  localparam logic [6:0] FUNCT7_ZERO   = 7'h00;
  localparam logic [6:0] FUNCT7_ALT    = 7'h20;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  // Action 0 is the illegal-instruction trap so a reset bundle reads as all zeros.
  typedef enum logic [ACTION_WIDTH-1:0] {
    decode_action_trap_illegal_instruction      = 4'd0,
    decode_action_trap_instruction_access_fault = 4'd1,
    decode_action_trap_ecall_ebreak             = 4'd2,
    decode_action_load                          = 4'd3,
    decode_action_store                         = 4'd4,
    decode_action_branch                        = 4'd5,
    decode_action_jal                           = 4'd6,
    decode_action_jalr                          = 4'd7,
    decode_action_lui                           = 4'd8,
    decode_action_auipc                         = 4'd9,
    decode_action_op_imm                        = 4'd10,
    decode_action_op                            = 4'd11,
    decode_action_muldiv                        = 4'd12,
    decode_action_fence                         = 4'd13,
    decode_action_fence_i                       = 4'd14,
    decode_action_csr                           = 4'd15
  } decode_action_t;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      opcode;
    logic [XLEN-1:0] immediate;
    decode_action_t  action;
  } decode_bundle_t;

endpackage

// File: rtl/cpu_decode_stage_comb.sv
// Purely combinational RV32I decoder: instruction word and fetch fault to a decoded bundle.
module cpu_decode_comb
  import cpu_decode_stage_pkg::*;
#(
  parameter bit ENABLE_M     = 1'b0,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic [XLEN-1:0] instruction,
  input  logic            fault,
  output decode_bundle_t  bundle_c
);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [4:0]      rs1;

  assign funct7 = instruction[31:25];
  assign funct3 = instruction[14:12];
  assign rd     = instruction[11:7];
  assign rs1    = instruction[19:15];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'd0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // Field extraction, immediate format selection and legality per opcode.
  always_comb begin
    bundle_c             = '0;
    bundle_c.instruction = instruction;
    bundle_c.funct7      = funct7;
    bundle_c.funct3      = funct3;
    bundle_c.rd          = rd;
    bundle_c.rs1         = rs1;
    bundle_c.rs2         = instruction[24:20];
    bundle_c.opcode      = instruction[6:0];
    bundle_c.immediate   = '0;
    bundle_c.action      = decode_action_trap_illegal_instruction;

    unique case (instruction[6:0])
      OPCODE_LOAD: begin
        bundle_c.immediate = imm_i;
        if (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) bundle_c.action = decode_action_load;
      end
      OPCODE_STORE: begin
        bundle_c.immediate = imm_s;
        if (funct3 inside {3'd0, 3'd1, 3'd2}) bundle_c.action = decode_action_store;
      end
      OPCODE_BRANCH: begin
        bundle_c.immediate = imm_b;
        if (funct3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7}) bundle_c.action = decode_action_branch;
      end
      OPCODE_JALR: begin
        bundle_c.immediate = imm_i;
        if (funct3 == 3'd0) bundle_c.action = decode_action_jalr;
      end
      OPCODE_JAL: begin
        bundle_c.immediate = imm_j;
        bundle_c.action    = decode_action_jal;
      end
      OPCODE_LUI: begin
        bundle_c.immediate = imm_u;
        bundle_c.action    = decode_action_lui;
      end
      OPCODE_AUIPC: begin
        bundle_c.immediate = imm_u;
        bundle_c.action    = decode_action_auipc;
      end
      OPCODE_OP_IMM: begin
        bundle_c.immediate = imm_i;
        if (funct3 == 3'd1) begin
          if (funct7 == FUNCT7_ZERO) bundle_c.action = decode_action_op_imm;
        end else if (funct3 == 3'd5) begin
          if (funct7 == FUNCT7_ZERO || funct7 == FUNCT7_ALT) bundle_c.action = decode_action_op_imm;
        end else begin
          bundle_c.action = decode_action_op_imm;
        end
      end
      OPCODE_OP: begin
        if (funct7 == FUNCT7_ZERO) begin
          bundle_c.action = decode_action_op;
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'd0 || funct3 == 3'd5) bundle_c.action = decode_action_op;
        end else if (funct7 == FUNCT7_MULDIV) begin
          if (ENABLE_M) bundle_c.action = decode_action_muldiv;
        end
      end
      OPCODE_MISC_MEM: begin
        bundle_c.immediate = imm_i;
        if (funct3 == 3'd0 && instruction[31:28] == 4'd0 && rs1 == 5'd0 && rd == 5'd0)
          bundle_c.action = decode_action_fence;
        else if (funct3 == 3'd1 && instruction[31:20] == 12'd0 && rs1 == 5'd0 && rd == 5'd0)
          bundle_c.action = decode_action_fence_i;
      end
      OPCODE_SYSTEM: begin
        bundle_c.immediate = imm_i;
        if (funct3 == 3'd0) begin
          if (rs1 == 5'd0 && rd == 5'd0 && instruction[31:21] == 11'd0)
            bundle_c.action = decode_action_trap_ecall_ebreak;
        end else if (funct3 != 3'd4) begin
          if (ENABLE_ZICSR) bundle_c.action = decode_action_csr;
        end
      end
      default: ;
    endcase

    // Compressed encodings are unsupported; a fetch fault overrides everything.
    if (instruction[1:0] != 2'b11) bundle_c.action = decode_action_trap_illegal_instruction;
    if (fault) bundle_c.action = decode_action_trap_instruction_access_fault;
  end

endmodule

// File: rtl/cpu_decode_stage.sv
// Registered decode stage: output register plus one skid entry, valid/ready on both sides, flush.
module cpu_decode_stage
  import cpu_decode_stage_pkg::*;
#(
  parameter bit          ENABLE_M     = 1'b0,
  parameter bit          ENABLE_ZICSR = 1'b1,
  parameter int unsigned PC_WIDTH     = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [XLEN-1:0]     fetch_instruction,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                fetch_fault,
  output logic                decode_valid,
  input  logic                decode_ready,
  output logic [PC_WIDTH-1:0] decode_pc,
  output logic [XLEN-1:0]     decode_instruction,
  output logic [6:0]          decode_funct7,
  output logic [2:0]          decode_funct3,
  output logic [4:0]          decode_rd,
  output logic [4:0]          decode_rs1,
  output logic [4:0]          decode_rs2,
  output logic [6:0]          decode_opcode,
  output logic [XLEN-1:0]     decode_immediate,
  output decode_action_t      decode_action
);

  decode_bundle_t      fetch_bundle_c;
  logic                out_valid_q, out_valid_d;
  decode_bundle_t      out_bundle_q, out_bundle_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                skid_valid_q, skid_valid_d;
  decode_bundle_t      skid_bundle_q, skid_bundle_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                in_fire_c;
  logic                out_fire_c;

  cpu_decode_comb #(
    .ENABLE_M     (ENABLE_M),
    .ENABLE_ZICSR (ENABLE_ZICSR)
  ) u_decode_comb (
    .instruction (fetch_instruction),
    .fault       (fetch_fault),
    .bundle_c    (fetch_bundle_c)
  );

  assign in_fire_c  = fetch_valid & ~skid_valid_q;
  assign out_fire_c = out_valid_q & decode_ready;

  // Next-state: flush first, then skid drain, then load of the incoming bundle.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_bundle_d  = out_bundle_q;
    out_pc_d      = out_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_bundle_d = skid_bundle_q;
    skid_pc_d     = skid_pc_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_fire_c) begin
        out_bundle_d = skid_bundle_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire_c) begin
      if (!out_valid_q || out_fire_c) begin
        out_valid_d  = 1'b1;
        out_bundle_d = fetch_bundle_c;
        out_pc_d     = fetch_pc;
      end else begin
        skid_valid_d  = 1'b1;
        skid_bundle_d = fetch_bundle_c;
        skid_pc_d     = fetch_pc;
      end
    end else if (out_fire_c) begin
      out_valid_d = 1'b0;
    end
  end

  // Bundle and valid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_bundle_q  <= '0;
      out_pc_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_bundle_q <= '0;
      skid_pc_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_bundle_q  <= out_bundle_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_bundle_q <= skid_bundle_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

  assign fetch_ready        = ~skid_valid_q;
  assign decode_valid       = out_valid_q;
  assign decode_pc          = out_pc_q;
  assign decode_instruction = out_bundle_q.instruction;
  assign decode_funct7      = out_bundle_q.funct7;
  assign decode_funct3      = out_bundle_q.funct3;
  assign decode_rd          = out_bundle_q.rd;
  assign decode_rs1         = out_bundle_q.rs1;
  assign decode_rs2         = out_bundle_q.rs2;
  assign decode_opcode      = out_bundle_q.opcode;
  assign decode_immediate   = out_bundle_q.immediate;
  assign decode_action      = out_bundle_q.action;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Scoreboard bench: two decode stages (M+Zicsr on, and both off) share one stimulus stream.
module tb_cpu_decode_stage;
  import cpu_decode_stage_pkg::*;

  localparam int unsigned PCW = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           flush;
  logic           fetch_valid;
  logic [31:0]    fetch_instruction;
  logic [PCW-1:0] fetch_pc;
  logic           fetch_fault;
  logic           decode_ready;

  logic a_fetch_ready, a_decode_valid, b_fetch_ready, b_decode_valid;
  logic [PCW-1:0] a_decode_pc, b_decode_pc;
  logic [31:0] a_decode_instruction, b_decode_instruction, a_decode_immediate, b_decode_immediate;
  logic [6:0] a_decode_funct7, b_decode_funct7, a_decode_opcode, b_decode_opcode;
  logic [2:0] a_decode_funct3, b_decode_funct3;
  logic [4:0] a_decode_rd, b_decode_rd, a_decode_rs1, b_decode_rs1, a_decode_rs2, b_decode_rs2;
  decode_action_t a_decode_action, b_decode_action;

  typedef struct {
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
    logic           fault;
  } txn_t;

  txn_t sb[$];
  txn_t head;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  cpu_decode_stage #(.ENABLE_M(1'b1), .ENABLE_ZICSR(1'b1), .PC_WIDTH(PCW)) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_ready(a_fetch_ready), .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
    .fetch_fault(fetch_fault), .decode_valid(a_decode_valid), .decode_ready(decode_ready),
    .decode_pc(a_decode_pc), .decode_instruction(a_decode_instruction),
    .decode_funct7(a_decode_funct7), .decode_funct3(a_decode_funct3), .decode_rd(a_decode_rd),
    .decode_rs1(a_decode_rs1), .decode_rs2(a_decode_rs2), .decode_opcode(a_decode_opcode),
    .decode_immediate(a_decode_immediate), .decode_action(a_decode_action)
  );

  cpu_decode_stage #(.ENABLE_M(1'b0), .ENABLE_ZICSR(1'b0), .PC_WIDTH(PCW)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_ready(b_fetch_ready), .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
    .fetch_fault(fetch_fault), .decode_valid(b_decode_valid), .decode_ready(decode_ready),
    .decode_pc(b_decode_pc), .decode_instruction(b_decode_instruction),
    .decode_funct7(b_decode_funct7), .decode_funct3(b_decode_funct3), .decode_rd(b_decode_rd),
    .decode_rs1(b_decode_rs1), .decode_rs2(b_decode_rs2), .decode_opcode(b_decode_opcode),
    .decode_immediate(b_decode_immediate), .decode_action(b_decode_action)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Immediate written as signed arithmetic on bit groups.
  function automatic logic [31:0] model_imm(input logic [31:0] w);
    int s;
    s = int'(w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: return 32'(s >>> 20);
      7'h23: return 32'((s >>> 25) * 32 + int'({27'd0, w[11:7]}));
      7'h63: return 32'((s >>> 31) * 4096 + int'({31'd0, w[7]}) * 2048
                        + int'({26'd0, w[30:25]}) * 32 + int'({28'd0, w[11:8]}) * 2);
      7'h37, 7'h17: return w & 32'hFFFFF000;
      7'h6F: return 32'((s >>> 31) * 1048576 + int'({24'd0, w[19:12]}) * 4096
                        + int'({31'd0, w[20]}) * 2048 + int'({22'd0, w[30:21]}) * 2);
      default: return 32'd0;
    endcase
  endfunction

  function automatic decode_action_t model_action(input logic [31:0] w, input bit fault,
                                                  input bit m, input bit zicsr);
    logic [2:0] f3;
    logic [6:0] f7;
    bit         regs_zero;
    f3 = w[14:12];
    f7 = w[31:25];
    regs_zero = (w[19:15] == 5'd0) && (w[11:7] == 5'd0);
    if (fault) return decode_action_trap_instruction_access_fault;
    if (w[1:0] != 2'b11) return decode_action_trap_illegal_instruction;
    case (w[6:0])
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) return decode_action_load;
      7'h23: if (f3 <= 3'd2) return decode_action_store;
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) return decode_action_branch;
      7'h67: if (f3 == 3'd0) return decode_action_jalr;
      7'h6F: return decode_action_jal;
      7'h37: return decode_action_lui;
      7'h17: return decode_action_auipc;
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) return decode_action_trap_illegal_instruction;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return decode_action_trap_illegal_instruction;
        return decode_action_op_imm;
      end
      7'h33: begin
        if (f7 == 7'h00) return decode_action_op;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return decode_action_op;
        if (f7 == 7'h01 && m) return decode_action_muldiv;
      end
      7'h0F: begin
        if (f3 == 3'd0 && w[31:28] == 4'd0 && regs_zero) return decode_action_fence;
        if (f3 == 3'd1 && w[31:20] == 12'd0 && regs_zero) return decode_action_fence_i;
      end
      7'h73: begin
        if (f3 == 3'd0 && regs_zero && (w[31:20] == 12'd0 || w[31:20] == 12'd1))
          return decode_action_trap_ecall_ebreak;
        if (f3 != 3'd0 && f3 != 3'd4 && zicsr) return decode_action_csr;
      end
      default: ;
    endcase
    return decode_action_trap_illegal_instruction;
  endfunction

  // Monitor: checks occupancy-derived handshake and the head bundle, then updates the model.
  always @(negedge clk) begin
    bit do_pop, do_push;
    if (!reset_n) begin
      sb.delete();
    end else begin
      check("a_valid", 128'(a_decode_valid), 128'(sb.size() > 0));
      check("b_valid", 128'(b_decode_valid), 128'(sb.size() > 0));
      check("a_fetch_ready", 128'(a_fetch_ready), 128'(sb.size() < 2));
      check("b_fetch_ready", 128'(b_fetch_ready), 128'(sb.size() < 2));
      if (sb.size() > 0) begin
        head = sb[0];
        check("a_action", 128'(a_decode_action), 128'(model_action(head.instr, head.fault, 1'b1, 1'b1)));
        check("b_action", 128'(b_decode_action), 128'(model_action(head.instr, head.fault, 1'b0, 1'b0)));
        check("a_imm", 128'(a_decode_immediate), 128'(model_imm(head.instr)));
        check("b_imm", 128'(b_decode_immediate), 128'(model_imm(head.instr)));
        check("a_fields",
              128'({a_decode_pc, a_decode_instruction, a_decode_funct7, a_decode_funct3,
                    a_decode_rd, a_decode_rs1, a_decode_rs2, a_decode_opcode}),
              128'({head.pc, head.instr, head.instr[31:25], head.instr[14:12], head.instr[11:7],
                    head.instr[19:15], head.instr[24:20], head.instr[6:0]}));
        check("b_fields",
              128'({b_decode_pc, b_decode_instruction, b_decode_funct7, b_decode_funct3,
                    b_decode_rd, b_decode_rs1, b_decode_rs2, b_decode_opcode}),
              128'({head.pc, head.instr, head.instr[31:25], head.instr[14:12], head.instr[11:7],
                    head.instr[19:15], head.instr[24:20], head.instr[6:0]}));
      end
      if (flush) begin
        sb.delete();
      end else begin
        do_pop  = (sb.size() > 0) && decode_ready;
        do_push = fetch_valid && (sb.size() < 2);
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back('{fetch_instruction, fetch_pc, fetch_fault});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until the stage takes it, with a bounded wait.
  task automatic offer(input logic [31:0] instr, input logic [PCW-1:0] pc, input logic fault);
    bit taken;
    taken = 1'b0;
    fetch_valid       = 1'b1;
    fetch_instruction = instr;
    fetch_pc          = pc;
    fetch_fault       = fault;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      taken = a_fetch_ready;
      step();
    end
    if (!taken) check("offer_timeout", 128'(0), 128'(1));
    fetch_valid = 1'b0;
    fetch_fault = 1'b0;
  endtask

  function automatic logic [31:0] random_instr();
    logic [6:0]  ops [11];
    logic [31:0] w;
    int unsigned sel;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    w   = $urandom;
    sel = $urandom_range(0, 12);
    if (sel < 11) w[6:0] = ops[sel];
    else if (sel == 12) w[1:0] = 2'($urandom_range(0, 2));
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 0) begin
      w[19:15] = 5'd0;
      w[11:7]  = 5'd0;
    end
    if ($urandom_range(0, 2) == 0) w[31:20] = 12'($urandom_range(0, 1));
    return w;
  endfunction

  initial begin
    reset_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_instruction = '0;
    fetch_pc = '0; fetch_fault = 1'b0; decode_ready = 1'b1;
    #2;
    check("reset_valid", 128'(a_decode_valid), 128'(0));
    check("reset_bundle", 128'({a_decode_pc, a_decode_instruction, a_decode_immediate, a_decode_action}), 128'(0));
    step();
    reset_n = 1'b1;
    step();
    check("reset_ready", 128'(a_fetch_ready), 128'(1));

    // Directed decode cases.
    offer(32'h00000013, 32'h100, 1'b0);
    offer(32'h02B50533, 32'h104, 1'b0);
    offer(32'h00000073, 32'h108, 1'b0);
    offer(32'h00100073, 32'h10C, 1'b0);
    offer(32'h00200073, 32'h110, 1'b0);
    offer(32'h00001073, 32'h114, 1'b0);
    offer(32'hFFFFFFFF, 32'h118, 1'b1);
    repeat (2) step();

    // Stall three cycles while fetching 0x0, 0x4, 0x8.
    decode_ready = 1'b0;
    offer(32'h00100093, 32'h0, 1'b0);
    offer(32'h00208113, 32'h4, 1'b0);
    check("stall_ready_low", 128'(a_fetch_ready), 128'(0));
    fork
      offer(32'h00310193, 32'h8, 1'b0);
      begin
        step();
        decode_ready = 1'b1;
      end
    join
    repeat (3) step();

    // Flush with a full skid and a simultaneous fetch handshake.
    decode_ready = 1'b0;
    offer(32'h00500293, 32'h20, 1'b0);
    offer(32'h00600313, 32'h24, 1'b0);
    flush = 1'b1; fetch_valid = 1'b1; fetch_instruction = 32'h00700393; fetch_pc = 32'h28;
    step();
    flush = 1'b0; fetch_valid = 1'b0;
    check("flush_valid", 128'(a_decode_valid), 128'(0));
    check("flush_ready", 128'(a_fetch_ready), 128'(1));
    decode_ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset in the middle of a stall.
    decode_ready = 1'b0;
    offer(32'h00800413, 32'h30, 1'b0);
    offer(32'h00900493, 32'h34, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", 128'({a_decode_valid, b_decode_valid}), 128'(0));
    check("async_reset_bundle", 128'({a_decode_pc, a_decode_instruction, a_decode_immediate, a_decode_action}), 128'(0));
    @(negedge clk);
    step();
    reset_n = 1'b1;
    decode_ready = 1'b1;
    step();
    check("post_reset_ready", 128'(a_fetch_ready), 128'(1));

    // Randomized traffic with random back-pressure and occasional flush.
    for (int c = 0; c < 1500; c++) begin
      decode_ready      = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 39) == 0);
      fetch_valid       = ($urandom_range(0, 3) != 0);
      fetch_instruction = random_instr();
      fetch_pc          = {$urandom_range(0, 32'h3FFF), 2'b00};
      fetch_fault       = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0; fetch_valid = 1'b0; fetch_fault = 1'b0; decode_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
